// File: rtl/hilo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_pkg
//  Description : Shared types and constants for the HI/LO register unit.
//                Holds the controller state encoding and the functional-unit
//                source indices (0 = divider, 1 = multiplier, matching the
//                legacy multCtrl encoding).
//  Revision    : 1.0 - initial release
// ============================================================================
package hilo_pkg;

   localparam int DEFAULT_WIDTH = 32;

   // Functional-unit source indices
   localparam int SRC_DIV  = 0;
   localparam int SRC_MULT = 1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

endpackage : hilo_pkg
`default_nettype wire

// File: rtl/hilo_if.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_if
//  Description : Bus between the control/datapath side and hilo_unit.
//                slave  modport : hilo_unit side
//                master modport : control unit / functional units side
//  Signals     : start/done (per-source pulses), hi_in/lo_in (flattened
//                per-source results), mthi/mtlo/wdata (register writes),
//                mf_req (read request), hi/lo/busy/owner/stall and the two
//                sticky error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hilo_if
   import hilo_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int NSRC  = 2,
   parameter int SRCW  = (NSRC > 1) ? $clog2(NSRC) : 1
);
   logic [NSRC-1:0]       start;
   logic [NSRC-1:0]       done;
   logic [NSRC*WIDTH-1:0] hi_in;
   logic [NSRC*WIDTH-1:0] lo_in;
   logic                  mthi;
   logic                  mtlo;
   logic [WIDTH-1:0]      wdata;
   logic                  mf_req;
   logic [WIDTH-1:0]      hi;
   logic [WIDTH-1:0]      lo;
   logic                  busy;
   logic [SRCW-1:0]       owner;
   logic                  stall;
   logic                  timeout_err;
   logic                  proto_err;

   modport slave (
      input  start, done, hi_in, lo_in, mthi, mtlo, wdata, mf_req,
      output hi, lo, busy, owner, stall, timeout_err, proto_err
   );

   modport master (
      output start, done, hi_in, lo_in, mthi, mtlo, wdata, mf_req,
      input  hi, lo, busy, owner, stall, timeout_err, proto_err
   );
endinterface : hilo_if
`default_nettype wire

// File: rtl/hilo_src_mux.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_src_mux
//  Description : NSRC:1 indexed mux selecting one WIDTH-bit slice of a
//                flattened per-source result bus.
//  Ports       : i_bus  - flattened bus, slice s = i_bus[s*WIDTH +: WIDTH]
//                i_sel  - source index
//                o_data - selected slice (zero for an out-of-range index)
//  Revision    : 1.0 - initial release
// ============================================================================
module hilo_src_mux
   import hilo_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int NSRC  = 2,
   parameter int SRCW  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
   input  wire logic [NSRC*WIDTH-1:0] i_bus,
   input  wire logic [SRCW-1:0]       i_sel,
   output logic      [WIDTH-1:0]      o_data
);

   always_comb begin
      o_data = '0;
      for (int s = 0; s < NSRC; s++) begin
         if (i_sel == SRCW'(s)) begin
            o_data = i_bus[s*WIDTH +: WIDTH];
         end
      end
   end

endmodule : hilo_src_mux
`default_nettype wire

// File: rtl/hilo_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_unit
//  Description : Owns the HI/LO registers. Tracks which multi-cycle unit has
//                an op in flight, captures its result on done, services
//                MTHI/MTLO, stalls MFHI/MFLO while busy and aborts hung ops
//                after TIMEOUT cycles.
//  Ports       : clk, reset (sync, active-high)
//                bus - hilo_if.slave (see hilo_if for the signal list)
//  Revision    : 1.0 - initial release
// ============================================================================
module hilo_unit
   import hilo_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int NSRC    = 2,
   parameter int SRCW    = (NSRC > 1) ? $clog2(NSRC) : 1,
   parameter int TIMEOUT = 64
) (
   input wire logic clk,
   input wire logic reset,
   hilo_if.slave    bus
);

   localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t            r_state, w_state_n;
   logic [SRCW-1:0]   r_owner, w_owner_n;
   logic [CNTW-1:0]   r_cnt,   w_cnt_n;
   logic [WIDTH-1:0]  r_hi,    w_hi_n;
   logic [WIDTH-1:0]  r_lo,    w_lo_n;
   logic              r_terr,  w_terr_n;
   logic              r_perr,  w_perr_n;

   logic              w_busy;
   logic              w_start_any;
   logic              w_start_onehot;
   logic [SRCW-1:0]   w_start_idx;
   logic [NSRC-1:0]   w_owner_mask;
   logic              w_owner_done;
   logic              w_bad_done;
   logic [WIDTH-1:0]  w_hi_sel;
   logic [WIDTH-1:0]  w_lo_sel;

   assign w_busy         = (r_state == BUSY);
   assign w_start_any    = |bus.start;
   // x & (x-1) clears the lowest set bit: zero result means at most one bit
   assign w_start_onehot = w_start_any && ((bus.start & (bus.start - 1'b1)) == '0);

   always_comb begin
      w_start_idx = '0;
      for (int s = 0; s < NSRC; s++) begin
         if (bus.start[s]) begin
            w_start_idx = SRCW'(s);
         end
      end
   end

   // Only the owner of an in-flight op may legally signal done
   assign w_owner_mask = w_busy ? (NSRC'(1) << r_owner) : '0;
   assign w_owner_done = |(bus.done & w_owner_mask);
   assign w_bad_done   = |(bus.done & ~w_owner_mask);

   hilo_src_mux #(.WIDTH(WIDTH), .NSRC(NSRC), .SRCW(SRCW)) u_hi_mux (
      .i_bus  (bus.hi_in),
      .i_sel  (r_owner),
      .o_data (w_hi_sel)
   );

   hilo_src_mux #(.WIDTH(WIDTH), .NSRC(NSRC), .SRCW(SRCW)) u_lo_mux (
      .i_bus  (bus.lo_in),
      .i_sel  (r_owner),
      .o_data (w_lo_sel)
   );

   // Priority: mthi/mtlo > start > done[owner] > timeout
   always_comb begin
      w_state_n = r_state;
      w_owner_n = r_owner;
      w_cnt_n   = w_busy ? (r_cnt + 1'b1) : '0;
      w_hi_n    = r_hi;
      w_lo_n    = r_lo;
      w_terr_n  = r_terr;
      w_perr_n  = r_perr | (w_start_any & ~w_start_onehot);

      if (bus.mthi || bus.mtlo) begin
         if (bus.mthi) w_hi_n = bus.wdata;
         if (bus.mtlo) w_lo_n = bus.wdata;
         w_state_n = IDLE;
         w_cnt_n   = '0;
         if (w_bad_done) w_perr_n = 1'b1;
      end else if (w_start_onehot) begin
         // A re-launch while busy swallows any same-cycle done silently
         w_state_n = BUSY;
         w_owner_n = w_start_idx;
         w_cnt_n   = '0;
         if (!w_busy && w_bad_done) w_perr_n = 1'b1;
      end else begin
         if (w_bad_done) w_perr_n = 1'b1;
         if (w_owner_done) begin
            w_hi_n    = w_hi_sel;
            w_lo_n    = w_lo_sel;
            w_state_n = IDLE;
            w_cnt_n   = '0;
         end else if (w_busy && (r_cnt == CNTW'(TIMEOUT - 1))) begin
            w_state_n = IDLE;
            w_terr_n  = 1'b1;
            w_cnt_n   = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_owner <= '0;
         r_cnt   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_terr  <= 1'b0;
         r_perr  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_owner <= w_owner_n;
         r_cnt   <= w_cnt_n;
         r_hi    <= w_hi_n;
         r_lo    <= w_lo_n;
         r_terr  <= w_terr_n;
         r_perr  <= w_perr_n;
      end
   end

   assign bus.hi          = r_hi;
   assign bus.lo          = r_lo;
   assign bus.busy        = w_busy;
   assign bus.owner       = r_owner;
   assign bus.stall       = bus.mf_req & w_busy;
   assign bus.timeout_err = r_terr;
   assign bus.proto_err   = r_perr;

endmodule : hilo_unit
`default_nettype wire

// File: tb/tb_hilo_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hilo_unit
//  Description : Directed self-checking bench for hilo_unit (TIMEOUT = 8).
//                Expected values are queued as stimulus is applied and
//                compared once the DUT has had its clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_unit;
   import hilo_pkg::*;

   localparam int W  = 32;
   localparam int N  = 2;
   localparam int SW = 1;
   localparam int TO = 8;

   localparam int F_HI = 0, F_LO = 1, F_BUSY = 2, F_OWNER = 3,
                  F_STALL = 4, F_TERR = 5, F_PERR = 6;

   typedef struct {
      string       tag;
      int          fld;
      logic [31:0] exp;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t q[$];

   always #5 clk = ~clk;

   hilo_if #(.WIDTH(W), .NSRC(N), .SRCW(SW)) bus ();

   hilo_unit #(.WIDTH(W), .NSRC(N), .SRCW(SW), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic logic [31:0] field(int f);
      case (f)
         F_HI:    return bus.hi;
         F_LO:    return bus.lo;
         F_BUSY:  return {31'b0, bus.busy};
         F_OWNER: return {31'b0, bus.owner};
         F_STALL: return {31'b0, bus.stall};
         F_TERR:  return {31'b0, bus.timeout_err};
         default: return {31'b0, bus.proto_err};
      endcase
   endfunction

   task automatic push(input string tag, input int f, input logic [31:0] v);
      exp_t e;
      e.tag = tag; e.fld = f; e.exp = v;
      q.push_back(e);
   endtask

   task automatic check_all();
      exp_t        e;
      logic [31:0] obs;
      while (q.size() > 0) begin
         e   = q.pop_front();
         obs = field(e.fld);
         vectors++;
         assert (obs === e.exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic clear_inputs();
      bus.start  = '0;
      bus.done   = '0;
      bus.mthi   = 1'b0;
      bus.mtlo   = 1'b0;
      bus.wdata  = '0;
      bus.mf_req = 1'b0;
   endtask

   task automatic set_src(input int s, input logic [31:0] h, input logic [31:0] l);
      bus.hi_in[s*W +: W] = h;
      bus.lo_in[s*W +: W] = l;
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      push({tag, "_hi"},    F_HI,    32'h0);
      push({tag, "_lo"},    F_LO,    32'h0);
      push({tag, "_busy"},  F_BUSY,  32'h0);
      push({tag, "_owner"}, F_OWNER, 32'h0);
      push({tag, "_terr"},  F_TERR,  32'h0);
      push({tag, "_perr"},  F_PERR,  32'h0);
      tick();
      reset = 1'b0;
   endtask

   task automatic check_stall(input string tag, input logic exp);
      bus.mf_req = 1'b1;
      #1;
      push(tag, F_STALL, {31'b0, exp});
      check_all();
      bus.mf_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      clear_inputs();
      bus.hi_in = '0;
      bus.lo_in = '0;
      tick();
      do_reset("rst0");

      // ---- multiplier op: start at cycle 1, done at cycle 5 ----
      bus.start = 2'(1 << SRC_MULT);
      push("t1_busy_c2", F_BUSY, 32'h1);
      push("t1_owner",   F_OWNER, 32'h1);
      tick();                                   // cycle 2
      bus.start = '0;
      tick();                                   // cycle 3
      push("t1_busy_c3", F_BUSY, 32'h1);
      tick();                                   // cycle 4
      check_stall("t1_stall_c4", 1'b1);
      push("t1_hi_hold", F_HI, 32'h0);
      tick();                                   // cycle 5
      bus.done = 2'(1 << SRC_MULT);
      set_src(SRC_MULT, 32'h0000_0001, 32'h8000_0000);
      push("t1_hi",    F_HI,    32'h0000_0001);
      push("t1_lo",    F_LO,    32'h8000_0000);
      push("t1_idle",  F_BUSY,  32'h0);
      push("t1_owner2", F_OWNER, 32'h1);
      push("t1_perr",  F_PERR,  32'h0);
      tick();                                   // cycle 6
      bus.done = '0;
      check_stall("t1_stall_c6", 1'b0);

      // ---- divider op with a stray multiplier done ----
      bus.start = 2'(1 << SRC_DIV);
      push("t2_owner", F_OWNER, 32'h0);
      tick();
      bus.start = '0;
      tick();
      bus.done = 2'(1 << SRC_MULT);
      set_src(SRC_MULT, 32'hAAAA_AAAA, 32'h5555_5555);
      push("t2_perr",   F_PERR, 32'h1);
      push("t2_hi_hold", F_HI,  32'h0000_0001);
      push("t2_lo_hold", F_LO,  32'h8000_0000);
      push("t2_busy",   F_BUSY, 32'h1);
      tick();
      bus.done = '0;
      tick();
      tick();
      tick();
      bus.done = 2'(1 << SRC_DIV);
      set_src(SRC_DIV, 32'h0000_0002, 32'h0000_0007);
      push("t2_hi", F_HI, 32'h0000_0002);
      push("t2_lo", F_LO, 32'h0000_0007);
      push("t2_idle", F_BUSY, 32'h0);
      tick();
      bus.done = '0;

      // ---- timeout: dual MTHI/MTLO preload, then a hung divider op ----
      do_reset("rst1");
      bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'h1234_5678;
      push("t3_mt_hi", F_HI, 32'h1234_5678);
      push("t3_mt_lo", F_LO, 32'h1234_5678);
      tick();
      clear_inputs();
      bus.start = 2'(1 << SRC_DIV);
      push("t3_busy_1", F_BUSY, 32'h1);
      tick();
      bus.start = '0;
      for (int i = 2; i <= 8; i++) begin
         push($sformatf("t3_busy_%0d", i), F_BUSY, 32'h1);
         tick();
      end
      push("t3_timeout_busy", F_BUSY, 32'h0);
      push("t3_timeout_err",  F_TERR, 32'h1);
      push("t3_hi_hold",      F_HI,   32'h1234_5678);
      push("t3_lo_hold",      F_LO,   32'h1234_5678);
      push("t3_perr_clear",   F_PERR, 32'h0);
      tick();
      bus.done = 2'(1 << SRC_DIV);
      set_src(SRC_DIV, 32'hFFFF_0000, 32'h0000_FFFF);
      push("t3_late_perr", F_PERR, 32'h1);
      push("t3_late_hi",   F_HI,   32'h1234_5678);
      tick();
      bus.done = '0;

      // ---- MTHI aborts an in-flight multiplier op ----
      do_reset("rst2");
      bus.start = 2'(1 << SRC_MULT);
      tick();
      bus.start = '0;
      tick();
      bus.mthi = 1'b1; bus.wdata = 32'hDEAD_BEEF;
      push("t4_hi",   F_HI,   32'hDEAD_BEEF);
      push("t4_busy", F_BUSY, 32'h0);
      push("t4_terr", F_TERR, 32'h0);
      push("t4_perr", F_PERR, 32'h0);
      tick();
      clear_inputs();
      tick();
      bus.done = 2'(1 << SRC_MULT);
      set_src(SRC_MULT, 32'h1111_1111, 32'h2222_2222);
      push("t4_late_perr", F_PERR, 32'h1);
      push("t4_late_hi",   F_HI,   32'hDEAD_BEEF);
      push("t4_late_lo",   F_LO,   32'h0);
      tick();
      bus.done = '0;

      // ---- MTLO beats a same-cycle owner done ----
      do_reset("rst3");
      bus.start = 2'(1 << SRC_DIV);
      tick();
      bus.start = '0;
      bus.mtlo = 1'b1; bus.wdata = 32'h0000_0005;
      bus.done = 2'(1 << SRC_DIV);
      set_src(SRC_DIV, 32'h0000_000A, 32'h0000_0009);
      push("t5_lo",   F_LO,   32'h0000_0005);
      push("t5_hi",   F_HI,   32'h0);
      push("t5_busy", F_BUSY, 32'h0);
      push("t5_perr", F_PERR, 32'h0);
      tick();
      clear_inputs();

      // ---- re-launch from divider to multiplier ----
      do_reset("rst4");
      bus.start = 2'(1 << SRC_DIV);
      tick();
      bus.start = '0;
      tick();
      bus.start = 2'(1 << SRC_MULT);
      bus.done  = 2'(1 << SRC_DIV);
      set_src(SRC_DIV, 32'h0BAD_0BAD, 32'h0BAD_0BAD);
      push("t6_owner", F_OWNER, 32'h1);
      push("t6_busy",  F_BUSY,  32'h1);
      push("t6_hi",    F_HI,    32'h0);
      push("t6_perr",  F_PERR,  32'h0);
      tick();
      bus.start = '0;
      bus.done  = '0;
      tick();
      bus.done = 2'(1 << SRC_MULT);
      set_src(SRC_MULT, 32'h0000_CAFE, 32'h0000_BEEF);
      push("t6_cap_hi", F_HI,   32'h0000_CAFE);
      push("t6_cap_lo", F_LO,   32'h0000_BEEF);
      push("t6_idle",   F_BUSY, 32'h0);
      push("t6_perr2",  F_PERR, 32'h0);
      tick();
      bus.done = '0;

      // ---- multi-hot start is a protocol error ----
      bus.start = 2'b11;
      push("t7_busy", F_BUSY, 32'h0);
      push("t7_perr", F_PERR, 32'h1);
      tick();
      bus.start = '0;

      // ---- reset mid-op, then a now-orphaned done ----
      do_reset("rst5");
      bus.start = 2'(1 << SRC_MULT);
      push("t8_busy", F_BUSY, 32'h1);
      tick();
      bus.start = '0;
      tick();
      do_reset("t8_rst");
      bus.done = 2'(1 << SRC_MULT);
      push("t8_orphan_perr", F_PERR, 32'h1);
      push("t8_orphan_hi",   F_HI,   32'h0);
      tick();
      bus.done = '0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_hilo_unit
`default_nettype wire
